// File: rtl/beagleg_pkg.sv
// Shared command protocol constants for the motion-segment SPI path.
// Host-side software mirrors these values, so they must not change.
package beagleg_pkg;

   // Bytes per motion-segment record and FIFO depth in records.
   localparam int RecordWords = 4;
   localparam int FifoDepth   = 16;

   // First byte of every chip-select frame.
   typedef enum logic [7:0] {
      CMD_NO_OP       = 8'h00,
      CMD_STATUS      = 8'h01,
      CMD_WRITE_FIFO  = 8'h02,
      CMD_CLEAR_FLAGS = 8'h03
   } command_e;

   // Bit positions inside the sticky flags vector {bad_cmd, truncated, overflow}.
   localparam int FLAG_OVERFLOW  = 0;
   localparam int FLAG_TRUNCATED = 1;
   localparam int FLAG_BAD_CMD   = 2;

endpackage

// File: rtl/record_pusher.sv
// Copies a completed record into a private buffer and writes it to the FIFO
// as a burst of RecordWords consecutive byte strobes, byte 0 first.
module record_pusher #(
   parameter int RecordWords = beagleg_pkg::RecordWords
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       load,
   input  logic [RecordWords*8-1:0]   record,
   output logic                       write_en,
   output logic [7:0]                 data,
   output logic                       active
);

   localparam int CntW = $clog2(RecordWords + 1);

   logic [RecordWords*8-1:0] buffer;
   logic [CntW-1:0]          cnt;

   // Load starts the burst with byte 0 on the next cycle; cnt then walks the
   // remaining bytes, and the burst ends once RecordWords bytes have gone out.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         buffer   <= '0;
         cnt      <= '0;
         write_en <= 1'b0;
         data     <= 8'h00;
         active   <= 1'b0;
      end else if (load) begin
         buffer   <= record;
         data     <= record[7:0];
         write_en <= 1'b1;
         active   <= 1'b1;
         cnt      <= CntW'(1);
      end else if (active) begin
         if (cnt == CntW'(RecordWords)) begin
            write_en <= 1'b0;
            active   <= 1'b0;
            data     <= 8'h00;
            cnt      <= '0;
         end else begin
            data <= buffer[int'(cnt)*8 +: 8];
            cnt  <= cnt + CntW'(1);
         end
      end
   end

endmodule

// File: rtl/spi_command_sequencer.sv
// Host command decoder: parses the first byte of each SPI frame, assembles
// WRITE_FIFO payload into whole records committed atomically to the FIFO,
// supplies the MISO byte and keeps sticky error flags.
module spi_command_sequencer #(
   parameter int RecordWords = beagleg_pkg::RecordWords,
   parameter int FifoDepth   = beagleg_pkg::FifoDepth
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        spi_cs,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic [7:0]  tx_byte,
   input  logic [7:0]  fifo_free_slots,
   output logic        fifo_write_en,
   output logic [7:0]  fifo_data,
   output logic [2:0]  flags,
   output logic [15:0] records_written
);

   import beagleg_pkg::*;

   localparam int IdxW = (RecordWords > 1) ? $clog2(RecordWords) : 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_STATUS  = 2'd1;
   localparam logic [1:0] ST_WRITE   = 2'd2;
   localparam logic [1:0] ST_DISCARD = 2'd3;

   logic [1:0]               state;
   logic [IdxW-1:0]          idx;
   logic [2:0]               stat_cnt;
   logic [7:0]               stage [RecordWords];
   logic [RecordWords*8-1:0] record;
   logic                     push_active;
   logic                     byte_in;
   logic                     rec_done;
   logic                     commit;
   logic [2:0]               flag_set;
   logic                     flag_clear;
   logic [2:0]               flags_q;
   logic [15:0]              rec_count;

   // Bytes only count while the frame is open; the last slot completes a record.
   assign byte_in  = rx_valid && !spi_cs;
   assign rec_done = byte_in && (state == ST_WRITE) && (idx == IdxW'(RecordWords - 1));
   // One slot is reserved for a record still being pushed out.
   assign commit   = rec_done && (fifo_free_slots > (push_active ? 8'd1 : 8'd0));

   assign flags           = flags_q;
   assign records_written = rec_count;

   // Completed record: staged bytes plus the byte arriving this cycle in the last slot.
   always_comb begin
      record = '0;
      for (int i = 0; i < RecordWords; i++) begin
         record[i*8 +: 8] = (i == RecordWords - 1) ? rx_byte : stage[i];
      end
   end

   // Flag set/clear requests for this cycle.
   always_comb begin
      flag_set   = '0;
      flag_clear = 1'b0;
      if (spi_cs) begin
         if ((state == ST_WRITE) && (idx != '0)) flag_set[FLAG_TRUNCATED] = 1'b1;
      end else if (rx_valid) begin
         if (state == ST_IDLE) begin
            case (rx_byte)
               CMD_NO_OP, CMD_STATUS, CMD_WRITE_FIFO: begin end
               CMD_CLEAR_FLAGS: flag_clear = 1'b1;
               default:         flag_set[FLAG_BAD_CMD] = 1'b1;
            endcase
         end
         if (rec_done && !commit) flag_set[FLAG_OVERFLOW] = 1'b1;
      end
   end

   // Command FSM: chip-select high always returns to IDLE with an empty staging index.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         idx      <= '0;
         stat_cnt <= '0;
      end else if (spi_cs) begin
         state    <= ST_IDLE;
         idx      <= '0;
         stat_cnt <= '0;
      end else if (rx_valid) begin
         case (state)
            ST_IDLE: begin
               stat_cnt <= '0;
               idx      <= '0;
               case (rx_byte)
                  CMD_STATUS:     state <= ST_STATUS;
                  CMD_WRITE_FIFO: state <= ST_WRITE;
                  default:        state <= ST_DISCARD;
               endcase
            end
            ST_STATUS: if (stat_cnt != 3'd4) stat_cnt <= stat_cnt + 3'd1;
            ST_WRITE:  idx <= rec_done ? '0 : idx + IdxW'(1);
            default: begin end
         endcase
      end
   end

   // Staging slots hold payload bytes until the record is complete.
   always_ff @(posedge clk) begin
      if ((state == ST_WRITE) && byte_in) stage[idx] <= rx_byte;
   end

   // MISO byte, registered from the current state and status index.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_byte <= 8'h00;
      end else begin
         case (state)
            ST_IDLE: tx_byte <= fifo_free_slots;
            ST_STATUS: begin
               case (stat_cnt)
                  3'd0:    tx_byte <= {5'b0, flags_q};
                  3'd1:    tx_byte <= rec_count[7:0];
                  3'd2:    tx_byte <= rec_count[15:8];
                  3'd3:    tx_byte <= {7'b0, fifo_free_slots == 8'(FifoDepth)};
                  default: tx_byte <= 8'h00;
               endcase
            end
            default: tx_byte <= 8'h00;
         endcase
      end
   end

   // Sticky flags: a set in the same cycle as a clear wins.
   always_ff @(posedge clk) begin
      if (!reset_n) flags_q <= '0;
      else          flags_q <= (flag_clear ? 3'b000 : flags_q) | flag_set;
   end

   // Committed-record counter, wrapping modulo 2^16.
   always_ff @(posedge clk) begin
      if (!reset_n)    rec_count <= '0;
      else if (commit) rec_count <= rec_count + 16'd1;
   end

   record_pusher #(
      .RecordWords (RecordWords)
   ) u_pusher (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (commit),
      .record   (record),
      .write_en (fifo_write_en),
      .data     (fifo_data),
      .active   (push_active)
   );

endmodule

// File: tb/tb_spi_command_sequencer.sv
// Directed bench for spi_command_sequencer: frames driven byte by byte with
// eight-cycle byte spacing, FIFO writes captured on the falling edge.
module tb_spi_command_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        spi_cs = 1'b1;
   logic [7:0]  rx_byte = 8'h00;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_byte;
   logic [7:0]  fifo_free_slots = 8'd16;
   logic        fifo_write_en;
   logic [7:0]  fifo_data;
   logic [2:0]  flags;
   logic [15:0] records_written;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_q[$];
   logic [7:0] wr_q[$];

   // Clock.
   always #5 clk = ~clk;

   spi_command_sequencer dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .spi_cs          (spi_cs),
      .rx_byte         (rx_byte),
      .rx_valid        (rx_valid),
      .tx_byte         (tx_byte),
      .fifo_free_slots (fifo_free_slots),
      .fifo_write_en   (fifo_write_en),
      .fifo_data       (fifo_data),
      .flags           (flags),
      .records_written (records_written)
   );

   // Capture every FIFO write away from the active edge.
   always @(negedge clk) begin
      if (fifo_write_en === 1'b1) wr_q.push_back(fifo_data);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_byte  = b;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
      tick(7);
   endtask

   task automatic frame_begin();
      spi_cs = 1'b0;
      tick(2);
   endtask

   task automatic frame_end();
      spi_cs = 1'b1;
      tick(3);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      tick(3);
      checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx: got %h expected 00", tx_byte); end
      checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", fifo_write_en); end
      checks++; if (fifo_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", fifo_data); end
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", flags); end
      checks++; if (records_written !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h expected 0000", records_written); end
      reset_n = 1'b1;
      tick(2);
      checks++; if (tx_byte !== 8'd16) begin errors++; $display("FAIL idle_tx: got %h expected 10", tx_byte); end
   endtask

   task automatic test_write_records();
      logic [7:0] payload[8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
      wr_q.delete();
      exp_q.delete();
      fifo_free_slots = 8'd16;
      frame_begin();
      send_byte(8'h02);
      for (int i = 0; i < 8; i++) begin
         send_byte(payload[i]);
         exp_q.push_back(payload[i]);
      end
      frame_end();
      checks++; if (wr_q.size() != exp_q.size()) begin errors++; $display("FAIL write_count: got %0d expected %0d", wr_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size(); i++) begin
         checks++;
         if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL write_data[%0d]: got %h expected %h", i, (i < wr_q.size()) ? wr_q[i] : 8'hxx, exp_q[i]);
         end
      end
      checks++; if (records_written !== 16'd2) begin errors++; $display("FAIL write_records: got %0d expected 2", records_written); end
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL write_flags: got %b expected 000", flags); end
      // Third record so the counter reads 3 for the status test.
      frame_begin();
      send_byte(8'h02);
      for (int i = 0; i < 4; i++) send_byte(8'h60 + 8'(i));
      frame_end();
      checks++; if (records_written !== 16'd3) begin errors++; $display("FAIL third_record: got %0d expected 3", records_written); end
   endtask

   task automatic test_overflow();
      wr_q.delete();
      fifo_free_slots = 8'd0;
      frame_begin();
      send_byte(8'h02);
      for (int i = 0; i < 4; i++) send_byte(8'h70 + 8'(i));
      frame_end();
      checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL overflow_writes: got %0d expected 0", wr_q.size()); end
      checks++; if (flags !== 3'b001) begin errors++; $display("FAIL overflow_flags: got %b expected 001", flags); end
      checks++; if (records_written !== 16'd3) begin errors++; $display("FAIL overflow_count: got %0d expected 3", records_written); end
   endtask

   task automatic test_status();
      fifo_free_slots = 8'd13;
      frame_begin();
      send_byte(8'h01);
      checks++; if (tx_byte !== 8'h01) begin errors++; $display("FAIL status_flags: got %h expected 01", tx_byte); end
      send_byte(8'hFF);
      checks++; if (tx_byte !== 8'h03) begin errors++; $display("FAIL status_count_lo: got %h expected 03", tx_byte); end
      send_byte(8'hFF);
      checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL status_count_hi: got %h expected 00", tx_byte); end
      send_byte(8'hFF);
      checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL status_not_empty: got %h expected 00", tx_byte); end
      fifo_free_slots = 8'd16;
      tick(2);
      checks++; if (tx_byte !== 8'h01) begin errors++; $display("FAIL status_empty: got %h expected 01", tx_byte); end
      send_byte(8'hFF);
      checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL status_tail: got %h expected 00", tx_byte); end
      frame_end();
   endtask

   task automatic test_truncate();
      wr_q.delete();
      fifo_free_slots = 8'd9;
      frame_begin();
      send_byte(8'h02);
      send_byte(8'h81);
      send_byte(8'h82);
      frame_end();
      checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL truncate_writes: got %0d expected 0", wr_q.size()); end
      checks++; if (flags !== 3'b011) begin errors++; $display("FAIL truncate_flags: got %b expected 011", flags); end
      checks++; if (tx_byte !== 8'd9) begin errors++; $display("FAIL truncate_idle_tx: got %h expected 09", tx_byte); end
   endtask

   task automatic test_flags_cmds();
      frame_begin();
      send_byte(8'h03);
      frame_end();
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL clear_flags: got %b expected 000", flags); end
      frame_begin();
      send_byte(8'h07);
      send_byte(8'h02);
      frame_end();
      checks++; if (flags !== 3'b100) begin errors++; $display("FAIL bad_cmd: got %b expected 100", flags); end
      frame_begin();
      send_byte(8'h03);
      frame_end();
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL bad_cmd_clear: got %b expected 000", flags); end
   endtask

   task automatic test_count_wrap();
      wr_q.delete();
      exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      fifo_free_slots = 8'd16;
      force dut.rec_count = 16'hFFFF;
      #1;
      release dut.rec_count;
      tick(1);
      checks++; if (records_written !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffff", records_written); end
      frame_begin();
      send_byte(8'h02);
      for (int i = 0; i < 4; i++) send_byte(exp_q[i]);
      frame_end();
      checks++; if (records_written !== 16'h0000) begin errors++; $display("FAIL wrap_count: got %h expected 0000", records_written); end
      checks++; if (wr_q.size() != 4) begin errors++; $display("FAIL wrap_writes: got %0d expected 4", wr_q.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (i >= wr_q.size() || wr_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL wrap_data[%0d]: got %h expected %h", i, (i < wr_q.size()) ? wr_q[i] : 8'hxx, exp_q[i]);
         end
      end
   endtask

   task automatic test_reset_mid_push();
      frame_begin();
      send_byte(8'h07);
      frame_end();
      wr_q.delete();
      frame_begin();
      send_byte(8'h02);
      send_byte(8'hD0);
      send_byte(8'hD1);
      send_byte(8'hD2);
      rx_byte  = 8'hD3;
      rx_valid = 1'b1;
      tick(1);
      rx_valid = 1'b0;
      checks++; if (fifo_write_en !== 1'b1 || fifo_data !== 8'hD0) begin errors++; $display("FAIL push_first: got we=%b data=%h expected we=1 data=d0", fifo_write_en, fifo_data); end
      checks++; if (records_written !== 16'd1) begin errors++; $display("FAIL push_count: got %0d expected 1", records_written); end
      tick(1);
      checks++; if (fifo_write_en !== 1'b1 || fifo_data !== 8'hD1) begin errors++; $display("FAIL push_second: got we=%b data=%h expected we=1 data=d1", fifo_write_en, fifo_data); end
      reset_n = 1'b0;
      spi_cs  = 1'b1;
      tick(1);
      checks++; if (fifo_write_en !== 1'b0) begin errors++; $display("FAIL abort_we: got %b expected 0", fifo_write_en); end
      checks++; if (fifo_data !== 8'h00) begin errors++; $display("FAIL abort_data: got %h expected 00", fifo_data); end
      checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL abort_tx: got %h expected 00", tx_byte); end
      checks++; if (flags !== 3'b000) begin errors++; $display("FAIL abort_flags: got %b expected 000", flags); end
      checks++; if (records_written !== 16'h0000) begin errors++; $display("FAIL abort_count: got %h expected 0000", records_written); end
      tick(4);
      checks++; if (wr_q.size() != 2) begin errors++; $display("FAIL abort_writes: got %0d expected 2", wr_q.size()); end
      fifo_free_slots = 8'd12;
      reset_n = 1'b1;
      tick(2);
      checks++; if (tx_byte !== 8'd12) begin errors++; $display("FAIL after_abort_tx: got %h expected 0c", tx_byte); end
   endtask

   initial begin
      test_reset();
      test_write_records();
      test_overflow();
      test_status();
      test_truncate();
      test_flags_cmds();
      test_count_wrap();
      test_reset_mid_push();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_command_sequencer.md
# spi_command_sequencer

Sits between the SPI secondary byte interface and the motion-segment FIFO, and owns the host command protocol. It decodes the first byte of each chip-select frame and assembles `WRITE_FIFO` payload bytes into whole 4-byte records, which it commits to the FIFO atomically. Records are dropped rather than split when space is short. It also supplies the byte to shift out on MISO (free slots, status, counters) and keeps sticky error flags for the host.

## Interface
- `RecordWords`, default 4: bytes per motion-segment record.
- `FifoDepth`, default 16: FIFO capacity in records, used for the status "empty" bit.
- `clk` in 1: system clock; all logic on the rising edge.
- `reset_n` in 1: reset, synchronous and active-low.
- `spi_cs` in 1: chip select, active-low, already synchronised to `clk`; high = frame ended.
- `rx_byte` in 8: byte received from host, valid while `rx_valid`.
- `rx_valid` in 1: one-cycle strobe per received byte.
- `tx_byte` out 8: byte the SPI secondary shifts out for the next transfer.
- `fifo_free_slots` in 8: free whole records, `FifoDepth - (size >> log2(RecordWords))`.
- `fifo_write_en` out 1: FIFO byte write strobe.
- `fifo_data` out 8: FIFO write data.
- `flags` out 3: sticky flags {bad_cmd, truncated, overflow}.
- `records_written` out 16: records committed since reset; wraps modulo 2^16.

## Operation
- Commands are the first byte of a frame: 0 NO_OP, 1 STATUS, 2 WRITE_FIFO, 3 CLEAR_FLAGS. The values are shared with host software.
- States:
  - IDLE: waits for the command byte.
  - STATUS: streams the status bytes.
  - WRITE: assembles records.
  - DISCARD: ignores bytes until `spi_cs` goes high.
- IDLE transitions on `rx_valid` while `spi_cs`=0:
  - NO_OP → DISCARD.
  - STATUS → STATUS.
  - WRITE_FIFO → WRITE.
  - CLEAR_FLAGS → `flags` cleared, then DISCARD.
  - Any other value → bad_cmd set, then DISCARD.
- `tx_byte` by state:
  - IDLE: `fifo_free_slots`.
  - STATUS, indexed by the byte count after the command: 0 = {5'b0, flags}; 1 = `records_written[7:0]`; 2 = `records_written[15:8]`; 3 = {7'b0, free==FifoDepth}; ≥4 = 0x00.
  - WRITE and DISCARD: 0x00.
- WRITE staging:
  - Each `rx_valid` byte goes into staging register slot `idx`, and `idx` increments.
  - When `idx` reaches `RecordWords`, the record is complete and `idx` returns to 0.
- Commit check on record completion: commit if `fifo_free_slots > (push_active ? 1 : 0)`.
  - Commit: copy staging into the push buffer, start a push, increment `records_written`.
  - Otherwise: drop the record and set overflow.
- Push engine is independent of the FSM. It emits `fifo_write_en`=1 for `RecordWords` consecutive cycles with buffer bytes 0..3 in order, then clears `push_active`.
- A second completion while `push_active` cannot occur: byte spacing is ≥8 `clk` cycles.
- `spi_cs` high in any state: next cycle state=IDLE and `idx`=0.
  - If `idx`≠0 in WRITE, the staged partial record is discarded and truncated is set.
  - An in-flight push always runs to completion.
- `rx_valid` while `spi_cs`=1 is ignored.
- Flags are set-only except by CLEAR_FLAGS or reset. If a set and CLEAR_FLAGS occur in the same cycle, the set wins.

## Timing
- Reset values:
  - State IDLE; `idx` 0.
  - `tx_byte` 0x00 in the reset cycle, then free slots.
  - `fifo_write_en` 0, `fifo_data` 0x00.
  - `flags` 0, `records_written` 0, `push_active` 0.
- `tx_byte` is registered and updates the cycle after the state or index change. It is stable ≥6 cycles before the next byte load.
- First `fifo_write_en` comes 1 cycle after the `rx_valid` of the final record byte. The 4 writes occupy cycles +1..+4.
- `records_written` increments in the same cycle as the first write.
- `fifo_data` is registered and aligned with `fifo_write_en`.
- `reset_n`=0 mid-push aborts the push immediately with no further writes. The FIFO is expected to share the reset.

## Structure
- Shared package `beagleg_pkg`: `command_e` enum (values above), `RecordWords`, `FifoDepth`, flag bit positions. Host-side `beagleg-protocol.cc` mirrors these.
- Sub-module `record_pusher`: buffer load, 4-cycle write burst, `push_active`. The FSM and staging stay in this module.
- Replaces the command FSM at the top level. The top level wires the SPI secondary and FIFO to this block.

## Test plan
- Reset, then frame [0x02, A0..A3, B0..B3] with 16 free → 8 writes A0..A3, B0..B3 in order; `records_written`=2; `flags`=0.
- `fifo_free_slots`=0, frame [0x02, 4 bytes] → no `fifo_write_en`; `flags`=3'b001.
- Frame [0x02, 2 bytes], then `spi_cs` high → no writes; truncated set; next idle `tx_byte` = free slots.
- Frame [0x01] after 3 records written → `tx_byte` sequence {flags}, 0x03, 0x00, 0x00, then 0x00.
- Frame [0x07] → bad_cmd set; then frame [0x03] → `flags`=0. Also `records_written`=0xFFFF plus one record → 0x0000.
- Pull `reset_n` low during the 2nd write of a push → `fifo_write_en` low the next cycle; all outputs return to their reset values.
